// File: rtl/bitser_pkg.sv
// rtl/bitser_pkg.sv - shared types, opcodes and decode helpers for the bit-serial sequencer
//
// Purpose: FSM state encoding, opcode constants, alu_op codes and small
//          combinational decode functions used by bitser_seq_ctrl.
// Ports:   none (package).
// Config:  BITSER_SEQ_CTRL_CMP_EN makes CMP/CMPI legal (compare without write-back).

package bitser_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXEC   = 2'd1,
      ST_WRITE  = 2'd2,
      ST_FINISH = 2'd3
   } state_t;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_OR   = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_XOR  = 4'b0110;
   localparam logic [3:0] OP_CMP  = 4'b0111;
   localparam logic [3:0] OP_ADDI = 4'b1000;
   localparam logic [3:0] OP_SUBI = 4'b1001;
   localparam logic [3:0] OP_ORI  = 4'b1010;
   localparam logic [3:0] OP_ANDI = 4'b1011;
   localparam logic [3:0] OP_XORI = 4'b1100;
   localparam logic [3:0] OP_CMPI = 4'b1101;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_XOR = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   // Compare opcodes: subtract that only updates zero_flag, no write-back.
   function automatic logic op_cmp(input logic [3:0] op);
`ifdef BITSER_SEQ_CTRL_CMP_EN
      return (op == OP_CMP) || (op == OP_CMPI);
`else
      return (op == 4'b1111) && (op == 4'b0000);
`endif
   endfunction

   // Operations that run the adder with B inverted and carry-in forced to 1.
   function automatic logic op_sub(input logic [3:0] op);
      return (op == OP_SUB) || (op == OP_SUBI) || op_cmp(op);
   endfunction

   function automatic logic op_legal(input logic [3:0] op);
      logic ok;
      ok = 1'b0;
      case (op)
         OP_ADD, OP_ADDI, OP_SUB, OP_SUBI,
         OP_XOR, OP_XORI, OP_AND, OP_ANDI,
         OP_OR,  OP_ORI:  ok = 1'b1;
         default:         ok = op_cmp(op);
      endcase
      return ok;
   endfunction

   function automatic logic [1:0] op_alu(input logic [3:0] op);
      logic [1:0] a;
      a = ALU_ADD;
      case (op)
         OP_XOR, OP_XORI: a = ALU_XOR;
         OP_AND, OP_ANDI: a = ALU_AND;
         OP_OR,  OP_ORI:  a = ALU_OR;
         default:         a = ALU_ADD;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/bitser_bit_counter.sv
// rtl/bitser_bit_counter.sv - bit position counter with terminal count
//
// Purpose: counts 0..WIDTH-1 while en is high and wraps to 0 after the
//          terminal count; clr has priority and forces 0.
// Ports:   clk, rstn (async active-low), clr, en -> count, tc (count == WIDTH-1).

module bitser_bit_counter #(
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     clr,
   input  logic                     en,
   output logic [$clog2(WIDTH)-1:0] count,
   output logic                     tc
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   assign tc = (count == LAST);

   // Explicit wrap at LAST so non-power-of-two WIDTH also cycles correctly.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= tc ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/bitser_seq_ctrl.sv
// rtl/bitser_seq_ctrl.sv - control sequencer for a bit-serial ALU datapath
//
// Purpose: accepts an instruction on go, runs WIDTH EXEC cycles driving the
//          serial ALU, WIDTH WRITE cycles shifting the result into the
//          accumulator, then a one-cycle FINISH with done.
// Ports:   clk, rstn (async active-low), opcode[3:0], inst_valid, go, res_bit
//          -> busy, done, illegal, reg_shift_en, acc_shift_en, acc_write_en,
//             carry_en, b_invert, carry_init, zero_flag, alu_op[1:0],
//             bit_idx[$clog2(WIDTH)-1:0].
// Config:  BITSER_SEQ_CTRL_CMP_EN enables CMP/CMPI (EXEC then FINISH, no WRITE).

module bitser_seq_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [3:0]               opcode,
   input  logic                     inst_valid,
   input  logic                     go,
   input  logic                     res_bit,
   output logic                     busy,
   output logic                     done,
   output logic                     illegal,
   output logic                     reg_shift_en,
   output logic                     acc_shift_en,
   output logic                     acc_write_en,
   output logic                     carry_en,
   output logic                     b_invert,
   output logic                     carry_init,
   output logic                     zero_flag,
   output logic [1:0]               alu_op,
   output logic [$clog2(WIDTH)-1:0] bit_idx
);

   import bitser_pkg::*;

   state_t     state_q;
   state_t     state_d;
   logic [3:0] op_q;
   logic       illegal_q;
   logic       any_one_q;
   logic       zero_flag_q;
   logic       tc;
   logic       start;
   logic       accept;
   logic       reject;
   logic       in_idle;
   logic       in_exec;
   logic       cnt_en;

   assign in_idle = (state_q == ST_IDLE);
   assign in_exec = (state_q == ST_EXEC);
   assign cnt_en  = in_exec || (state_q == ST_WRITE);

   // go is only looked at in IDLE, so go while busy cannot disturb op_q.
   assign start   = in_idle && go && inst_valid;
   assign accept  = start && op_legal(opcode);
   assign reject  = start && !op_legal(opcode);

   // Counter is held clear in IDLE, which keeps bit_idx at 0 there.
   bitser_bit_counter #(
      .WIDTH (WIDTH)
   ) u_bit_counter (
      .clk   (clk),
      .rstn  (rstn),
      .clr   (in_idle),
      .en    (cnt_en),
      .count (bit_idx),
      .tc    (tc)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         illegal_q   <= 1'b0;
         any_one_q   <= 1'b0;
         zero_flag_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= reject;
         if (accept) begin
            op_q <= opcode;
         end
         // The final sample is folded in directly so zero_flag is valid in
         // the first cycle after EXEC.
         if (in_exec) begin
            if (tc) begin
               zero_flag_q <= ~(any_one_q | res_bit);
               any_one_q   <= 1'b0;
            end else begin
               any_one_q <= any_one_q | res_bit;
            end
         end
      end
   end

   assign illegal   = illegal_q;
   assign zero_flag = zero_flag_q;

   always_comb begin
      state_d      = state_q;
      busy         = 1'b0;
      done         = 1'b0;
      reg_shift_en = 1'b0;
      acc_shift_en = 1'b0;
      acc_write_en = 1'b0;
      carry_en     = 1'b0;
      b_invert     = 1'b0;
      carry_init   = 1'b0;
      alu_op       = ALU_ADD;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            busy         = 1'b1;
            reg_shift_en = 1'b1;
            carry_en     = 1'b1;
            alu_op       = op_alu(op_q);
            b_invert     = op_sub(op_q);
            carry_init   = op_sub(op_q) && (bit_idx == '0);
            if (tc) begin
               state_d = op_cmp(op_q) ? ST_FINISH : ST_WRITE;
            end
         end
         ST_WRITE: begin
            busy         = 1'b1;
            acc_shift_en = 1'b1;
            acc_write_en = 1'b1;
            if (tc) begin
               state_d = ST_FINISH;
            end
         end
         ST_FINISH: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_bitser_seq_ctrl.sv
// tb/tb_bitser_seq_ctrl.sv - scoreboard testbench for bitser_seq_ctrl

module tb_bitser_seq_ctrl;

   localparam int WIDTH = 8;
   localparam int BW    = $clog2(WIDTH);

`ifdef BITSER_SEQ_CTRL_CMP_EN
   localparam bit CMP_EN = 1'b1;
`else
   localparam bit CMP_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [3:0]    opcode = '0;
   logic          inst_valid = 1'b0;
   logic          go = 1'b0;
   logic          res_bit = 1'b0;
   logic          busy, done, illegal, reg_shift_en, acc_shift_en, acc_write_en;
   logic          carry_en, b_invert, carry_init, zero_flag;
   logic [1:0]    alu_op;
   logic [BW-1:0] bit_idx;

   bitser_seq_ctrl #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .opcode       (opcode),
      .inst_valid   (inst_valid),
      .go           (go),
      .res_bit      (res_bit),
      .busy         (busy),
      .done         (done),
      .illegal      (illegal),
      .reg_shift_en (reg_shift_en),
      .acc_shift_en (acc_shift_en),
      .acc_write_en (acc_write_en),
      .carry_en     (carry_en),
      .b_invert     (b_invert),
      .carry_init   (carry_init),
      .zero_flag    (zero_flag),
      .alu_op       (alu_op),
      .bit_idx      (bit_idx)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          busy;
      logic          done;
      logic          illegal;
      logic          reg_shift_en;
      logic          acc_shift_en;
      logic          acc_write_en;
      logic          carry_en;
      logic          b_invert;
      logic          carry_init;
      logic          zero_flag;
      logic [1:0]    alu_op;
      logic [BW-1:0] bit_idx;
   } obs_t;

   typedef struct {
      int cyc;
      bit is_done;
   } evt_t;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   bit   zf_m = 1'b0;
   obs_t exp_map [int];
   evt_t evq [$];
   obs_t mon_o;
   evt_t mon_ev;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference decode, straight from the opcode table.
   function automatic bit is_cmp(input logic [3:0] op);
      return CMP_EN && (op == 4'b0111 || op == 4'b1101);
   endfunction

   function automatic bit is_sub(input logic [3:0] op);
      return (op == 4'b0001 || op == 4'b1001 || is_cmp(op));
   endfunction

   function automatic bit is_legal(input logic [3:0] op);
      case (op)
         4'b0000, 4'b1000, 4'b0001, 4'b1001, 4'b0110,
         4'b1100, 4'b0101, 4'b1011, 4'b0100, 4'b1010: return 1'b1;
         default: return is_cmp(op);
      endcase
   endfunction

   function automatic logic [1:0] alu_ref(input logic [3:0] op);
      case (op)
         4'b0110, 4'b1100: return 2'b01;
         4'b0101, 4'b1011: return 2'b10;
         4'b0100, 4'b1010: return 2'b11;
         default:          return 2'b00;
      endcase
   endfunction

   function automatic obs_t get_obs();
      obs_t o;
      o.busy = busy;                 o.done = done;
      o.illegal = illegal;           o.reg_shift_en = reg_shift_en;
      o.acc_shift_en = acc_shift_en; o.acc_write_en = acc_write_en;
      o.carry_en = carry_en;         o.b_invert = b_invert;
      o.carry_init = carry_init;     o.zero_flag = zero_flag;
      o.alu_op = alu_op;             o.bit_idx = bit_idx;
      return o;
   endfunction

   function automatic obs_t idle_obs();
      obs_t e;
      e = '0;
      e.zero_flag = zf_m;
      return e;
   endfunction

   function automatic obs_t exec_obs(input logic [3:0] op, input int i);
      obs_t e;
      e = '0;
      e.busy = 1'b1;
      e.reg_shift_en = 1'b1;
      e.carry_en = 1'b1;
      e.alu_op = alu_ref(op);
      e.b_invert = is_sub(op);
      e.carry_init = is_sub(op) && (i == 0);
      e.bit_idx = BW'(i);
      e.zero_flag = zf_m;
      return e;
   endfunction

   task automatic exp_cycle(input obs_t e);
      exp_map[cyc] = e;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Random opcode/valid churn; optional go that the busy DUT must ignore.
   task automatic drive_noise(input bit g);
      go = g;
      inst_valid = g ? 1'b1 : 1'($urandom);
      opcode = 4'($urandom);
      res_bit = 1'($urandom);
   endtask

   task automatic run_inst(input logic [3:0] op, input logic [WIDTH-1:0] rb, input bit extra_go);
      obs_t e;
      evt_t ev;
      bit   cmp;
      cmp = is_cmp(op);
      ev.cyc = cyc + (cmp ? WIDTH + 1 : 2 * WIDTH + 1);
      ev.is_done = 1'b1;
      evq.push_back(ev);
      opcode = op; inst_valid = 1'b1; go = 1'b1; res_bit = 1'($urandom);
      exp_cycle(idle_obs());
      step();
      for (int i = 0; i < WIDTH; i++) begin
         drive_noise(extra_go && i == 2);
         res_bit = rb[i];
         exp_cycle(exec_obs(op, i));
         step();
      end
      zf_m = (rb == '0);
      if (!cmp) begin
         for (int i = 0; i < WIDTH; i++) begin
            drive_noise(extra_go && i == 4);
            e = '0;
            e.busy = 1'b1; e.acc_shift_en = 1'b1; e.acc_write_en = 1'b1;
            e.bit_idx = BW'(i); e.zero_flag = zf_m;
            exp_cycle(e);
            step();
         end
      end
      drive_noise(extra_go);
      e = '0;
      e.busy = 1'b1; e.done = 1'b1; e.zero_flag = zf_m;
      exp_cycle(e);
      step();
      go = 1'b0;
   endtask

   task automatic run_illegal(input logic [3:0] op);
      evt_t ev;
      opcode = op; inst_valid = 1'b1; go = 1'b1;
      ev.cyc = cyc + 1; ev.is_done = 1'b0;
      evq.push_back(ev);
      exp_cycle(idle_obs());
      step();
      go = 1'b0;
      begin
         obs_t e;
         e = idle_obs();
         e.illegal = 1'b1;
         exp_cycle(e);
      end
      step();
   endtask

   task automatic run_novalid(input logic [3:0] op);
      opcode = op; inst_valid = 1'b0; go = 1'b1;
      exp_cycle(idle_obs());
      step();
      go = 1'b0;
      exp_cycle(idle_obs());
      step();
   endtask

   task automatic issue(input logic [3:0] op, input logic [WIDTH-1:0] rb, input bit extra_go);
      if (is_legal(op)) run_inst(op, rb, extra_go);
      else run_illegal(op);
   endtask

   // Monitor: per-cycle output scoreboard plus done/illegal event queue.
   always @(negedge clk) begin
      mon_o = get_obs();
      if (exp_map.exists(cyc)) begin
         checks++;
         if (mon_o !== exp_map[cyc]) begin
            errors++;
            $display("FAIL outputs cyc=%0d got=%h exp=%h", cyc, mon_o, exp_map[cyc]);
         end
         exp_map.delete(cyc);
      end
      if (mon_o.done === 1'b1 || mon_o.illegal === 1'b1) begin
         checks++;
         if (evq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event cyc=%0d done=%b illegal=%b exp=none", cyc, mon_o.done, mon_o.illegal);
         end else begin
            mon_ev = evq.pop_front();
            if (mon_ev.cyc != cyc || mon_ev.is_done != mon_o.done) begin
               errors++;
               $display("FAIL event_timing got cyc=%0d done=%b exp cyc=%0d done=%b",
                        cyc, mon_o.done, mon_ev.cyc, mon_ev.is_done);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout cyc=%0d exp=finish", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0]       op;
      logic [WIDTH-1:0] rb;
      step();
      repeat (2) begin
         exp_cycle(idle_obs());
         step();
      end
      rstn = 1'b1;
      exp_cycle(idle_obs());
      step();

      run_inst(4'b0000, 8'h00, 1'b0);
      run_inst(4'b0001, 8'h20, 1'b0);
      run_illegal(4'b1111);
      run_inst(4'b0000, WIDTH'($urandom), 1'b1);
      run_novalid(4'b0000);

      // ADD interrupted by reset at bit_idx 3.
      opcode = 4'b0000; inst_valid = 1'b1; go = 1'b1;
      exp_cycle(idle_obs());
      step();
      go = 1'b0;
      for (int i = 0; i < 3; i++) begin
         res_bit = 1'($urandom);
         exp_cycle(exec_obs(4'b0000, i));
         step();
      end
      rstn = 1'b0;
      #1;
      checks++;
      if (get_obs() !== obs_t'(0)) begin
         errors++;
         $display("FAIL reset_immediate got=%h exp=%h", get_obs(), obs_t'(0));
      end
      zf_m = 1'b0;
      exp_cycle(idle_obs());
      step();
      exp_cycle(idle_obs());
      step();
      rstn = 1'b1;
      exp_cycle(idle_obs());
      step();
      run_inst(4'b0000, 8'h01, 1'b0);

      issue(4'b0111, 8'h00, 1'b0);
      issue(4'b1101, 8'h40, 1'b1);

      for (int n = 0; n < 40; n++) begin
         op = 4'($urandom);
         rb = ($urandom_range(0, 2) == 0) ? '0 : WIDTH'($urandom);
         if ($urandom_range(0, 4) == 0) run_novalid(op);
         else issue(op, rb, 1'($urandom));
         repeat ($urandom_range(0, 2)) begin
            drive_noise(1'b0);
            exp_cycle(idle_obs());
            step();
         end
      end

      repeat (3) begin
         exp_cycle(idle_obs());
         step();
      end
      checks++;
      if (evq.size() != 0) begin
         errors++;
         $display("FAIL pending_events got=%0d exp=0", evq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
